// File: rtl/soc_bootrom_pkg.sv
// soc_bootrom_pkg: shared AHB3-Lite constants, bridge state encoding and size check
// Contents:
//   HTRANS_* / HRESP_*  bus encodings
//   state_t             bridge FSM states
//   size_ok()           true when hsize does not exceed the data bus width
package soc_bootrom_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

    function automatic logic size_ok(input logic [2:0] hsize, input logic [2:0] max_size);
        return hsize <= max_size;
    endfunction

endpackage

// File: rtl/soc_bootrom_ahb3_bridge.sv
// soc_bootrom_ahb3_bridge: AHB3-Lite read-only slave front end for a combinational boot ROM
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ahb3_*_i            AHB3-Lite slave address/control/write-data inputs
//   ahb3_hrdata_o       read data
//   ahb3_hreadyout_o    data phase complete
//   ahb3_hresp_o        0=OKAY 1=ERROR
//   rom_addr_o          registered word index to the ROM lookup
//   rom_data_i          ROM word for rom_addr_o
// Configuration macro:
//   SOC_BOOTROM_RDATA_REG_EN  register rom_data_i before hrdata_o (one extra wait cycle)
module soc_bootrom_ahb3_bridge
    import soc_bootrom_pkg::*;
#(
    parameter int PLEN        = 32,
    parameter int XLEN        = 32,
    parameter int ROM_AW      = 6,
    parameter int ROM_WORDS   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ahb3_hsel_i,
    input  logic [PLEN-1:0]   ahb3_haddr_i,
    input  logic [XLEN-1:0]   ahb3_hwdata_i,
    input  logic              ahb3_hwrite_i,
    input  logic [2:0]        ahb3_hsize_i,
    input  logic [2:0]        ahb3_hburst_i,
    input  logic [3:0]        ahb3_hprot_i,
    input  logic [1:0]        ahb3_htrans_i,
    input  logic              ahb3_hmastlock_i,
    input  logic              ahb3_hready_i,
    output logic [XLEN-1:0]   ahb3_hrdata_o,
    output logic              ahb3_hreadyout_o,
    output logic              ahb3_hresp_o,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [XLEN-1:0]   rom_data_i
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(XLEN/8));
`ifdef SOC_BOOTROM_RDATA_REG_EN
    localparam int WAIT_LOAD = WAIT_STATES + 1;
`else
    localparam int WAIT_LOAD = WAIT_STATES;
`endif

    state_t            state, state_nx;
    logic [4:0]        cnt, cnt_nx;
    logic [ROM_AW-1:0] rom_addr_nx;
    logic [XLEN-1:0]   rdata_q;
    logic              accept, bad, unused;
    logic [ROM_AW-1:0] idx;

    assign unused = ^{ahb3_hwdata_i, ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i, ahb3_haddr_i[1:0]};
    assign accept = ahb3_hsel_i & ahb3_htrans_i[1] & ahb3_hready_i;
    assign idx    = ahb3_haddr_i[ROM_AW+1:2];
    assign bad    = ahb3_hwrite_i | !size_ok(ahb3_hsize_i, MAX_SIZE) |
                    (32'(idx) >= ROM_WORDS) | ((ahb3_haddr_i >> (ROM_AW+2)) != '0);

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        rom_addr_nx = rom_addr_o;
        if (state == WAIT) begin
            cnt_nx   = cnt - 5'd1;
            state_nx = cnt == 5'd1 ? DATA : WAIT;
        end else if (state == ERR1) begin
            state_nx = ERR2;
        end else begin
            state_nx = IDLE;
            if (accept && bad) begin
                state_nx = ERR1;
            end else if (accept) begin
                rom_addr_nx = idx;
                cnt_nx      = 5'(WAIT_LOAD);
                state_nx    = WAIT_LOAD == 0 ? DATA : WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rom_addr_o <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            rom_addr_o <= rom_addr_nx;
        end
    end

`ifdef SOC_BOOTROM_RDATA_REG_EN
    // Capture on the last wait cycle so hrdata_o only changes on entry to DATA.
    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= (state == WAIT && cnt == 5'd1) ? rom_data_i : rdata_q;
    end
    assign ahb3_hrdata_o = rdata_q;
`else
    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= state == DATA ? rom_data_i : rdata_q;
    end
    assign ahb3_hrdata_o = state == DATA ? rom_data_i : rdata_q;
`endif

    assign ahb3_hreadyout_o = !(state == WAIT || state == ERR1);
    assign ahb3_hresp_o     = (state == ERR1 || state == ERR2) ? HRESP_ERROR : HRESP_OKAY;

endmodule
